// File: rtl/sorted_ram_writer.sv
// Insertion-sort loader for the single-port table RAM read by the binary searcher.
// Shifts larger entries up one address, then writes the new value into the gap.
module sorted_ram_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              dropped
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CMP,
    S_PLACE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   v_reg, v_next;
  logic [ADDR_W-1:0]   i_reg, i_next;
  logic [ADDR_W-1:0]   pos_reg, pos_next;
  logic [ADDR_W:0]     count_reg, count_next;
  logic                dropped_reg, dropped_next;

  logic [ADDR_W:0]     count_m1;
  logic [ADDR_W-1:0]   i_inc;
  logic                full_int;
  logic                shift_up;

  assign count_m1 = count_reg - 1'b1;
  assign i_inc    = i_reg + 1'b1;
  assign full_int = (count_reg == DEPTH_C);
  assign shift_up = (ram_rdata > v_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      v_reg       <= '0;
      i_reg       <= '0;
      pos_reg     <= '0;
      count_reg   <= '0;
      dropped_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      v_reg       <= v_next;
      i_reg       <= i_next;
      pos_reg     <= pos_next;
      count_reg   <= count_next;
      dropped_reg <= dropped_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    v_next       = v_reg;
    i_next       = i_reg;
    pos_next     = pos_reg;
    count_next   = count_reg;
    dropped_next = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    ram_we       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (clear) begin
          count_next = '0;
        end else if (start && full_int) begin
          dropped_next = 1'b1;
        end else if (start && (count_reg == '0)) begin
          v_next     = data_in;
          pos_next   = '0;
          state_next = S_PLACE;
        end else if (start) begin
          v_next     = data_in;
          i_next     = count_m1[ADDR_W-1:0];
          state_next = S_RD;
        end
      end
      S_RD: begin
        ram_addr   = i_reg;
        state_next = S_CMP;
      end
      S_CMP: begin
        // Strictly-greater test keeps equal values in arrival order.
        if (shift_up) begin
          ram_addr  = i_inc;
          ram_wdata = ram_rdata;
          ram_we    = 1'b1;
          if (i_reg == '0) begin
            pos_next   = '0;
            state_next = S_PLACE;
          end else begin
            i_next     = i_reg - 1'b1;
            state_next = S_RD;
          end
        end else begin
          pos_next   = i_inc;
          state_next = S_PLACE;
        end
      end
      S_PLACE: begin
        ram_addr   = pos_reg;
        ram_wdata  = v_reg;
        ram_we     = 1'b1;
        count_next = count_reg + 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign count   = count_reg;
  assign busy    = (state_reg != S_IDLE);
  assign done    = (state_reg == S_DONE);
  assign full    = full_int;
  assign dropped = dropped_reg;

endmodule

// File: tb/tb_sorted_ram_writer.sv
// Directed bench for sorted_ram_writer with a behavioural 32x8 registered-read RAM.
module tb_sorted_ram_writer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       clear;
  logic [7:0] data_in;
  logic [7:0] ram_rdata;
  logic [4:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [5:0] count;
  logic       busy;
  logic       done;
  logic       full;
  logic       dropped;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [32];
  logic [4:0] wr_addr [$];
  logic [7:0] wr_data [$];

  sorted_ram_writer #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
    .data_in(data_in), .ram_rdata(ram_rdata), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .count(count), .busy(busy),
    .done(done), .full(full), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model plus a log of every write the DUT issues
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_wdata);
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic do_insert(input logic [7:0] val, input bit pulse_busy,
                           output int cyc, output int busy_cyc,
                           output logic [5:0] cnt_at_done, output bit timeout);
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk);
    start   = 1'b1;
    data_in = val;
    @(posedge clk);
    #1;
    start    = 1'b0;
    data_in  = ~val;
    cyc      = 0;
    busy_cyc = 0;
    timeout  = 1'b1;
    cnt_at_done = '0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (pulse_busy && n == 0) begin
        start   = 1'b1;
        data_in = 8'd1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        timeout     = 1'b0;
        cnt_at_done = count;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic build_10_20_30();
    int c, b;
    logic [5:0] cd;
    bit t;
    do_clear();
    do_insert(8'd10, 1'b0, c, b, cd, t);
    do_insert(8'd20, 1'b0, c, b, cd, t);
    do_insert(8'd30, 1'b0, c, b, cd, t);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    clear   = 1'b0;
    data_in = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, dropped, full, ram_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=00000", {busy, done, dropped, full, ram_we});
    end
    checks++;
    if ({ram_addr, ram_wdata, count} !== 19'd0) begin
      errors++;
      $display("FAIL reset_bus addr=%0d wdata=%0d count=%0d want all 0", ram_addr, ram_wdata, count);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_insert();
    int c, b;
    logic [5:0] cd;
    bit t;
    do_insert(8'd10, 1'b0, c, b, cd, t);
    checks++;
    if (t || c != 1 || b != 2) begin
      errors++;
      $display("FAIL first_timing cyc=%0d busy=%0d timeout=%0d want cyc=1 busy=2", c, b, t);
    end
    checks++;
    if (cd !== 6'd1) begin
      errors++;
      $display("FAIL first_count got=%0d want=1", cd);
    end
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 5'd0 || wr_data[0] !== 8'd10) begin
      errors++;
      $display("FAIL first_writes n=%0d want one write addr0=10", wr_addr.size());
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL first_idle done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_sorted_build();
    int c, b;
    logic [5:0] cd;
    bit t;
    logic [7:0] exp_ram [3] = '{8'd10, 8'd20, 8'd30};
    do_clear();
    do_insert(8'd30, 1'b0, c, b, cd, t);
    checks++;
    if (t || c != 1) begin errors++; $display("FAIL build30_cyc got=%0d want=1", c); end
    do_insert(8'd10, 1'b0, c, b, cd, t);
    checks++;
    if (t || c != 3) begin errors++; $display("FAIL build10_cyc got=%0d want=3", c); end
    do_insert(8'd20, 1'b0, c, b, cd, t);
    checks++;
    if (t || c != 5) begin errors++; $display("FAIL build20_cyc got=%0d want=5", c); end
    checks++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 5'd2 || wr_data[0] !== 8'd30 ||
        wr_addr[1] !== 5'd1 || wr_data[1] !== 8'd20) begin
      errors++;
      $display("FAIL build20_writes n=%0d want addr2=30 addr1=20", wr_addr.size());
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (mem[j] !== exp_ram[j]) begin
        errors++;
        $display("FAIL build_ram[%0d] got=%0d want=%0d", j, mem[j], exp_ram[j]);
      end
    end
    checks++;
    if (cd !== 6'd3) begin errors++; $display("FAIL build_count got=%0d want=3", cd); end
  endtask

  task automatic test_shift_all();
    int c, b;
    logic [5:0] cd;
    bit t;
    logic [4:0] ea [4] = '{5'd3, 5'd2, 5'd1, 5'd0};
    logic [7:0] ed [4] = '{8'd30, 8'd20, 8'd10, 8'd5};
    logic [7:0] er [4] = '{8'd5, 8'd10, 8'd20, 8'd30};
    build_10_20_30();
    do_insert(8'd5, 1'b0, c, b, cd, t);
    checks++;
    if (t || c != 7 || b != 8) begin
      errors++;
      $display("FAIL shift_timing cyc=%0d busy=%0d want cyc=7 busy=8", c, b);
    end
    checks++;
    if (wr_addr.size() != 4) begin
      errors++;
      $display("FAIL shift_nwrites got=%0d want=4", wr_addr.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (wr_addr[j] !== ea[j] || wr_data[j] !== ed[j]) begin
          errors++;
          $display("FAIL shift_write%0d got addr%0d=%0d want addr%0d=%0d", j, wr_addr[j], wr_data[j], ea[j], ed[j]);
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (mem[j] !== er[j]) begin
        errors++;
        $display("FAIL shift_ram[%0d] got=%0d want=%0d", j, mem[j], er[j]);
      end
    end
  endtask

  task automatic test_equal_and_busy();
    int c, b;
    logic [5:0] cd;
    bit t;
    bit extra;
    logic [7:0] er [4] = '{8'd10, 8'd20, 8'd20, 8'd30};
    build_10_20_30();
    do_insert(8'd20, 1'b1, c, b, cd, t);
    checks++;
    if (t || c != 5) begin errors++; $display("FAIL equal_cyc got=%0d want=5", c); end
    checks++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 5'd3 || wr_data[0] !== 8'd30 ||
        wr_addr[1] !== 5'd2 || wr_data[1] !== 8'd20) begin
      errors++;
      $display("FAIL equal_writes n=%0d want addr3=30 addr2=20", wr_addr.size());
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (mem[j] !== er[j]) begin
        errors++;
        $display("FAIL equal_ram[%0d] got=%0d want=%0d", j, mem[j], er[j]);
      end
    end
    extra = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy || done) extra = 1'b1;
    end
    checks++;
    if (extra || count !== 6'd4) begin
      errors++;
      $display("FAIL busy_start_ignored count=%0d extra=%0d want count=4 extra=0", count, extra);
    end
  endtask

  task automatic test_fill();
    int c, b;
    logic [5:0] cd;
    bit t;
    int bad;
    do_clear();
    bad = 0;
    for (int v = 31; v >= 0; v--) begin
      do_insert(8'(v), 1'b0, c, b, cd, t);
      if (t || c != 2 * (31 - v) + 1 || cd !== 6'(32 - v)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fill_timing bad_inserts=%0d want=0", bad); end
    checks++;
    if (count !== 6'd32 || full !== 1'b1) begin
      errors++;
      $display("FAIL fill_full count=%0d full=%b want 32 1", count, full);
    end
    bad = 0;
    for (int j = 0; j < 32; j++) if (mem[j] !== 8'(j)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fill_sorted bad_entries=%0d want=0", bad); end
  endtask

  task automatic test_dropped();
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk);
    start   = 1'b1;
    data_in = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (dropped !== 1'b1 || busy !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL dropped_pulse dropped=%b busy=%b we=%b want 1 0 0", dropped, busy, ram_we);
    end
    @(negedge clk);
    checks++;
    if (dropped !== 1'b0 || count !== 6'd32 || wr_addr.size() != 0) begin
      errors++;
      $display("FAIL dropped_after dropped=%b count=%0d writes=%0d want 0 32 0", dropped, count, wr_addr.size());
    end
    do_clear();
    checks++;
    if (count !== 6'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL clear count=%0d full=%b want 0 0", count, full);
    end
  endtask

  task automatic test_reset_mid();
    int c, b;
    logic [5:0] cd;
    bit t;
    bit saw_done;
    build_10_20_30();
    @(negedge clk);
    start   = 1'b1;
    data_in = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 5'd3) begin
      errors++;
      $display("FAIL mid_cmp we=%b addr=%0d want 1 3", ram_we, ram_addr);
    end
    wr_addr.delete();
    wr_data.delete();
    reset_n = 1'b0;
    #1;
    checks++;
    if (ram_we !== 1'b0 || busy !== 1'b0 || count !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset we=%b busy=%b count=%0d want 0 0 0", ram_we, busy, count);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done || wr_addr.size() != 0) begin
      errors++;
      $display("FAIL mid_quiet done_seen=%b writes=%0d want 0 0", saw_done, wr_addr.size());
    end
    do_insert(8'd8, 1'b0, c, b, cd, t);
    checks++;
    if (t || c != 1 || cd !== 6'd1 || wr_addr.size() != 1 ||
        wr_addr[0] !== 5'd0 || wr_data[0] !== 8'd8) begin
      errors++;
      $display("FAIL post_reset_insert cyc=%0d count=%0d writes=%0d want 1 1 1", c, cd, wr_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_first_insert();
    test_sorted_build();
    test_shift_all();
    test_equal_and_busy();
    test_fill();
    test_dropped();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
